nts_extractor_arbiter: RTL and testbench
========================================

Name: nts_extractor_arbiter

Overview:
- Shares the extractor's packet buffers between ENGINES NTS engines.
- Round-robin grants one engine with a pending TX packet and pulses that engine's FIFO read-start.
- Streams the engine's 64-bit FIFO words into the currently selected extractor buffer (ping-pong, 2 buffers), then hands the completed packet to the MAC side.
- Sits between the engine TX FIFOs and the extractor RAM/MAC transmit logic.

Parameters:
- ENGINES, 4, number of engines arbitrated (1..16).
- ADDR_WIDTH, 8, word address width per buffer; capacity 2**ADDR_WIDTH 64-bit words.
- TIMEOUT, 255, maximum idle cycles in START_WAIT/READ before abort.

Ports:
- i_clk  in  1  clock
- i_areset  in  1  asynchronous reset, active high
- i_engine_packet_available  in  ENGINES  engine has a complete TX packet
- i_engine_fifo_empty  in  ENGINES  engine TX FIFO empty
- o_engine_fifo_rd_start  out  ENGINES  one-cycle start pulse to the granted engine
- i_engine_fifo_rd_valid  in  ENGINES  engine word valid
- i_engine_fifo_rd_data  in  ENGINES*64  engine word; engine e at [64*e+:64]
- i_engine_bytes_last_word  in  ENGINES*4  valid bytes in last word (1..8); engine e at [4*e+:4]
- i_buffer_free  in  2  MAC side: buffer n may be written
- o_ram_write  out  1  RAM write strobe
- o_ram_buffer  out  1  buffer index for the write
- o_ram_addr  out  ADDR_WIDTH  word address
- o_ram_wdata  out  64  word data
- o_packet_done  out  1  one-cycle pulse, packet committed
- o_packet_buffer  out  1  buffer holding the committed packet
- o_packet_words  out  ADDR_WIDTH+1  word count of the committed packet
- o_packet_bytes_last_word  out  4  bytes in the final word
- o_error  out  1  one-cycle pulse on overflow or timeout abort
- o_grant  out  4  index of the current/last granted engine

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr=0; buf_sel=0; word_cnt=0; timer=0.
- All state is registered. Outputs are driven from registers, one cycle after the causing input.
- States: IDLE, START, START_WAIT, READ, DONE, ABORT.
- IDLE: when any packet_available bit is set and i_buffer_free[buf_sel]=1, grant the first engine at or above rr_ptr, searching cyclically. Latch g; o_grant=g; go to START.
- If buf_sel is not free: stay in IDLE and issue no grant. The other buffer is never used out of order.
- START: o_engine_fifo_rd_start[g]=1 for exactly one cycle; timer=0; word_cnt=0; go to START_WAIT.
- START_WAIT: wait for rd_valid[g].
  - First valid word: o_ram_write=1, o_ram_addr=0, o_ram_buffer=buf_sel, data=word; word_cnt=1; go to READ.
  - timer reaches TIMEOUT: go to ABORT.
- READ: each rd_valid[g] writes at addr word_cnt; word_cnt increments; timer clears.
  - rd_valid[g]=0 and fifo_empty[g]=1: latch bytes_last_word[g]; go to DONE.
  - rd_valid=0 and FIFO not empty: timer increments; timer reaching TIMEOUT goes to ABORT.
  - Valid word arriving when word_cnt==2**ADDR_WIDTH: not written; go to ABORT (overflow).
- DONE: o_packet_done=1, o_packet_buffer=buf_sel, o_packet_words=word_cnt, o_packet_bytes_last_word=latched value. Then buf_sel toggles, rr_ptr=(g+1) mod ENGINES, go to IDLE.
- ABORT: o_error=1 for one cycle. buf_sel unchanged (buffer reused). rr_ptr=(g+1) mod ENGINES. Back to IDLE. Further words from g are not drained; the engine must flush itself.
- Only engine g's valid, data and empty inputs are observed while granted. Valid inputs from other engines are ignored.
- packet_available[g] dropping mid-transfer is ignored.
- Timer width is clog2(TIMEOUT+1).
- Reset asserted mid-transfer: immediate return to reset values. No done or error pulse is produced.
- Single engine (ENGINES=1): rr_ptr stays 0.

Test Plan:
- Engine 0 available, buf 0 free, 3 words A,B,C with last-word bytes 5, then empty -> exactly 1 rd_start[0] pulse; RAM writes buf0 addr 0,1,2; o_packet_done with buffer 0, words 3, bytes 5; buf_sel becomes 1.
- Engines 0 and 2 both continuously available, both buffers free, each sending 1-word packets -> grants in order 0,2,0,2; packets alternate buffers 0,1,0,1.
- i_buffer_free=2'b10 with buf_sel=0 and engine 1 available -> no rd_start for 20 cycles; setting free[0]=1 -> rd_start[1] one cycle after the IDLE grant.
- ADDR_WIDTH=2, engine sends 5 words -> addresses 0..3 written; 5th word not written; o_error pulse; no o_packet_done; buf_sel unchanged.
- TIMEOUT=10, engine never asserts rd_valid after start -> o_error exactly 11 cycles after START_WAIT entry; next grant goes to engine (g+1).
- i_areset pulsed after 2 words of a 4-word packet -> all outputs 0 asynchronously; rr_ptr=0; buf_sel=0; fresh grant of engine 0 after reset release.

Source files
------------

// File: rtl/nts_extractor_arbiter.sv
// nts_extractor_arbiter: round-robin arbiter that moves one TX packet at a
// time from an NTS engine FIFO into a ping-pong pair of extractor buffers
// and hands each completed packet to the MAC side.
module nts_extractor_arbiter #(
    parameter int ENGINES    = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_areset,
    input  logic [ENGINES-1:0]      i_engine_packet_available,
    input  logic [ENGINES-1:0]      i_engine_fifo_empty,
    output logic [ENGINES-1:0]      o_engine_fifo_rd_start,
    input  logic [ENGINES-1:0]      i_engine_fifo_rd_valid,
    input  logic [ENGINES*64-1:0]   i_engine_fifo_rd_data,
    input  logic [ENGINES*4-1:0]    i_engine_bytes_last_word,
    input  logic [1:0]              i_buffer_free,
    output logic                    o_ram_write,
    output logic                    o_ram_buffer,
    output logic [ADDR_WIDTH-1:0]   o_ram_addr,
    output logic [63:0]             o_ram_wdata,
    output logic                    o_packet_done,
    output logic                    o_packet_buffer,
    output logic [ADDR_WIDTH:0]     o_packet_words,
    output logic [3:0]              o_packet_bytes_last_word,
    output logic                    o_error,
    output logic [3:0]              o_grant
);

    localparam int PW = (ENGINES > 1) ? $clog2(ENGINES) : 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0]       TMO = TW'(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0]       LAST_ENG = PW'(ENGINES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_START_WAIT,
        S_READ,
        S_DONE,
        S_ABORT
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_rr_ptr;
    logic [PW-1:0]       r_g;
    logic                r_buf_sel;
    logic [ADDR_WIDTH:0] r_word_cnt;
    logic [TW-1:0]       r_timer;
    logic [3:0]          r_last_bytes;

    logic                w_found;
    logic [PW-1:0]       w_pick;
    logic [PW-1:0]       w_idx;
    logic                w_vld;
    logic                w_empty;
    logic [63:0]         w_data;
    logic [3:0]          w_bytes;
    logic [TW-1:0]       w_timer_inc;
    logic                w_timer_hit;
    logic [PW-1:0]       w_rr_next;

    // Only the granted engine's FIFO signals are ever looked at.
    assign w_vld       = i_engine_fifo_rd_valid[r_g];
    assign w_empty     = i_engine_fifo_empty[r_g];
    assign w_data      = i_engine_fifo_rd_data[64*r_g +: 64];
    assign w_bytes     = i_engine_bytes_last_word[4*r_g +: 4];
    assign w_timer_inc = r_timer + 1'b1;
    assign w_timer_hit = (w_timer_inc == TMO);
    assign w_rr_next   = (r_g == LAST_ENG) ? '0 : r_g + 1'b1;

    // Cyclic search for the first engine with a packet, starting at rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < ENGINES; i++) begin
            w_idx = PW'((int'(r_rr_ptr) + i) % ENGINES);
            if (!w_found && i_engine_packet_available[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Arbitration / transfer FSM with all outputs registered.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            r_state                  <= S_IDLE;
            r_rr_ptr                 <= '0;
            r_g                      <= '0;
            r_buf_sel                <= 1'b0;
            r_word_cnt               <= '0;
            r_timer                  <= '0;
            r_last_bytes             <= '0;
            o_engine_fifo_rd_start   <= '0;
            o_ram_write              <= 1'b0;
            o_ram_buffer             <= 1'b0;
            o_ram_addr               <= '0;
            o_ram_wdata              <= '0;
            o_packet_done            <= 1'b0;
            o_packet_buffer          <= 1'b0;
            o_packet_words           <= '0;
            o_packet_bytes_last_word <= '0;
            o_error                  <= 1'b0;
            o_grant                  <= '0;
        end else begin
            o_engine_fifo_rd_start <= '0;
            o_ram_write            <= 1'b0;
            o_packet_done          <= 1'b0;
            o_error                <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Buffers are consumed strictly in order; wait for ours.
                    if (w_found && i_buffer_free[r_buf_sel]) begin
                        r_g     <= w_pick;
                        o_grant <= 4'(w_pick);
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    o_engine_fifo_rd_start[r_g] <= 1'b1;
                    r_timer    <= '0;
                    r_word_cnt <= '0;
                    r_state    <= S_START_WAIT;
                end
                S_START_WAIT: begin
                    if (w_vld) begin
                        o_ram_write  <= 1'b1;
                        o_ram_buffer <= r_buf_sel;
                        o_ram_addr   <= '0;
                        o_ram_wdata  <= w_data;
                        r_word_cnt   <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                        r_timer      <= '0;
                        r_state      <= S_READ;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timer_hit) r_state <= S_ABORT;
                    end
                end
                S_READ: begin
                    if (w_vld) begin
                        if (r_word_cnt == CAP) begin
                            // Buffer full: drop the word and abandon the packet.
                            r_state <= S_ABORT;
                        end else begin
                            o_ram_write  <= 1'b1;
                            o_ram_buffer <= r_buf_sel;
                            o_ram_addr   <= r_word_cnt[ADDR_WIDTH-1:0];
                            o_ram_wdata  <= w_data;
                            r_word_cnt   <= r_word_cnt + 1'b1;
                            r_timer      <= '0;
                        end
                    end else if (w_empty) begin
                        r_last_bytes <= w_bytes;
                        r_state      <= S_DONE;
                    end else begin
                        r_timer <= w_timer_inc;
                        if (w_timer_hit) r_state <= S_ABORT;
                    end
                end
                S_DONE: begin
                    o_packet_done            <= 1'b1;
                    o_packet_buffer          <= r_buf_sel;
                    o_packet_words           <= r_word_cnt;
                    o_packet_bytes_last_word <= r_last_bytes;
                    r_buf_sel                <= ~r_buf_sel;
                    r_rr_ptr                 <= w_rr_next;
                    r_state                  <= S_IDLE;
                end
                S_ABORT: begin
                    // Buffer is reused; the engine flushes its own leftovers.
                    o_error  <= 1'b1;
                    r_rr_ptr <= w_rr_next;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nts_extractor_arbiter.sv
// Directed bench for nts_extractor_arbiter: behavioural engine responders,
// an output monitor, a table of single-packet vectors and a few sequences.
module tb_nts_extractor_arbiter;

    localparam int E  = 4;
    localparam int AW = 2;
    localparam int TO = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [E-1:0]    avail = '0;
    logic [E-1:0]    empty = '1;
    logic [E-1:0]    valid = '0;
    logic [E*64-1:0] data  = '0;
    logic [E*4-1:0]  lbw   = '0;
    logic [1:0]      bfree = 2'b11;

    logic [E-1:0]    o_rd_start;
    logic            o_ram_write;
    logic            o_ram_buffer;
    logic [AW-1:0]   o_ram_addr;
    logic [63:0]     o_ram_wdata;
    logic            o_packet_done;
    logic            o_packet_buffer;
    logic [AW:0]     o_packet_words;
    logic [3:0]      o_packet_bytes;
    logic            o_error;
    logic [3:0]      o_grant;

    nts_extractor_arbiter #(.ENGINES(E), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .i_clk                     (clk),
        .i_areset                  (rst),
        .i_engine_packet_available (avail),
        .i_engine_fifo_empty       (empty),
        .o_engine_fifo_rd_start    (o_rd_start),
        .i_engine_fifo_rd_valid    (valid),
        .i_engine_fifo_rd_data     (data),
        .i_engine_bytes_last_word  (lbw),
        .i_buffer_free             (bfree),
        .o_ram_write               (o_ram_write),
        .o_ram_buffer              (o_ram_buffer),
        .o_ram_addr                (o_ram_addr),
        .o_ram_wdata               (o_ram_wdata),
        .o_packet_done             (o_packet_done),
        .o_packet_buffer           (o_packet_buffer),
        .o_packet_words            (o_packet_words),
        .o_packet_bytes_last_word  (o_packet_bytes),
        .o_error                   (o_error),
        .o_grant                   (o_grant)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          b;
        logic [AW-1:0] a;
        logic [63:0]   d;
    } wr_t;
    typedef struct {
        logic        b;
        logic [AW:0] w;
        logic [3:0]  by;
    } done_t;
    typedef struct {
        int eng;
        int nw;
        int lb;
        int exp_err;
        int exp_buf;
        int exp_words;
        int exp_wr;
    } vec_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    grant_q[$];
    int    start_cnt[E];
    int    err_cnt   = 0;
    int    err_cyc   = 0;
    int    start_cyc = 0;
    int    cyc       = 0;

    int    len[E];
    int    lbv[E];
    bit    silent[E];
    bit    keep[E];

    int    n_chk  = 0;
    int    n_fail = 0;

    function automatic logic [63:0] pat(input int e, input int k);
        return {32'hDA7A0000 | 32'(e), 32'(k)};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_evt(input int d0, input int e0, input string nm);
        int i;
        i = 0;
        while (done_q.size() == d0 && err_cnt == e0 && i < 100) begin
            tick();
            i++;
        end
        n_chk++;
        if (i >= 100) begin
            n_fail++;
            $display("FAIL %s: no done/error within 100 cycles", nm);
        end
    endtask

    task automatic wait_grant(input int g0, input string nm);
        int i;
        i = 0;
        while (grant_q.size() == g0 && i < 100) begin
            tick();
            i++;
        end
        n_chk++;
        if (i >= 100) begin
            n_fail++;
            $display("FAIL %s: no rd_start within 100 cycles", nm);
        end
    endtask

    // Cycle counter on the active edge.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (o_ram_write) wr_q.push_back('{o_ram_buffer, o_ram_addr, o_ram_wdata});
        if (o_packet_done) done_q.push_back('{o_packet_buffer, o_packet_words, o_packet_bytes});
        if (o_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
        for (int e = 0; e < E; e++) begin
            if (o_rd_start[e]) begin
                start_cnt[e]++;
                grant_q.push_back(e);
                start_cyc = cyc;
            end
        end
    end

    // Engine model: on rd_start stream len[e] words, then go empty.
    initial forever begin
        int ge;
        @(negedge clk);
        if (|o_rd_start) begin
            ge = 0;
            for (int e = E - 1; e >= 0; e--) if (o_rd_start[e]) ge = e;
            if (!keep[ge]) avail[ge] = 1'b0;
            empty[ge] = 1'b0;
            if (!silent[ge]) begin
                lbw[4*ge +: 4] = 4'(lbv[ge]);
                for (int k = 0; k < len[ge]; k++) begin
                    valid[ge] = 1'b1;
                    data[64*ge +: 64] = pat(ge, k);
                    @(negedge clk);
                end
                valid[ge] = 1'b0;
                empty[ge] = 1'b1;
            end
        end
    end

    vec_t vt[5];

    initial begin
        int d0, e0, w0, g0, s0, sc, i;

        vt[0] = '{0, 3, 5, 0, 0, 3, 3};
        vt[1] = '{1, 1, 8, 0, 1, 1, 1};
        vt[2] = '{3, 4, 1, 0, 0, 4, 4};
        vt[3] = '{2, 5, 6, 1, 1, 0, 4};
        vt[4] = '{2, 2, 3, 0, 1, 2, 2};
        for (int e = 0; e < E; e++) begin
            len[e] = 1; lbv[e] = 8; silent[e] = 1'b0; keep[e] = 1'b0; start_cnt[e] = 0;
        end

        rst = 1'b1;
        #1;
        chk("rst_rd_start", 64'(o_rd_start), 0);
        chk("rst_ram_write", 64'(o_ram_write), 0);
        chk("rst_done", 64'(o_packet_done), 0);
        chk("rst_error", 64'(o_error), 0);
        chk("rst_grant", 64'(o_grant), 0);
        chk("rst_words", 64'(o_packet_words), 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single-packet vectors, buffers always free.
        for (int v = 0; v < 5; v++) begin
            d0 = done_q.size(); e0 = err_cnt; w0 = wr_q.size(); s0 = start_cnt[vt[v].eng];
            len[vt[v].eng] = vt[v].nw;
            lbv[vt[v].eng] = vt[v].lb;
            avail[vt[v].eng] = 1'b1;
            wait_evt(d0, e0, $sformatf("v%0d_wait", v));
            tick();
            chk($sformatf("v%0d_starts", v), 64'(start_cnt[vt[v].eng] - s0), 1);
            chk($sformatf("v%0d_grant", v), 64'(o_grant), 64'(vt[v].eng));
            chk($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vt[v].exp_err));
            if (vt[v].exp_err == 0) begin
                chk($sformatf("v%0d_done_buf", v), 64'(done_q[d0].b), 64'(vt[v].exp_buf));
                chk($sformatf("v%0d_done_words", v), 64'(done_q[d0].w), 64'(vt[v].exp_words));
                chk($sformatf("v%0d_done_bytes", v), 64'(done_q[d0].by), 64'(vt[v].lb));
            end else begin
                chk($sformatf("v%0d_no_done", v), 64'(done_q.size() - d0), 0);
            end
            chk($sformatf("v%0d_nwr", v), 64'(wr_q.size() - w0), 64'(vt[v].exp_wr));
            for (int k = 0; k < vt[v].exp_wr; k++) begin
                chk($sformatf("v%0d_wr%0d_buf", v, k), 64'(wr_q[w0+k].b), 64'(vt[v].exp_buf));
                chk($sformatf("v%0d_wr%0d_addr", v, k), 64'(wr_q[w0+k].a), 64'(k));
                chk($sformatf("v%0d_wr%0d_data", v, k), wr_q[w0+k].d, pat(vt[v].eng, k));
            end
        end

        // Engines 0 and 2 continuously available: grants alternate 0,2,0,2.
        g0 = grant_q.size(); d0 = done_q.size();
        len[0] = 1; len[2] = 1; keep[0] = 1'b1; keep[2] = 1'b1;
        avail[0] = 1'b1; avail[2] = 1'b1;
        i = 0;
        while (done_q.size() < d0 + 4 && i < 200) begin
            tick();
            i++;
        end
        avail[0] = 1'b0; avail[2] = 1'b0; keep[0] = 1'b0; keep[2] = 1'b0;
        repeat (5) tick();
        chk("alt_ngrants", 64'(grant_q.size() - g0), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("alt_grant%0d", k), 64'(grant_q[g0+k]), (k % 2) ? 2 : 0);
            chk($sformatf("alt_buf%0d", k), 64'(done_q[d0+k].b), 64'(k % 2));
        end

        // Selected buffer (0) busy while buffer 1 is free: no grant.
        bfree = 2'b10; s0 = start_cnt[1]; d0 = done_q.size(); e0 = err_cnt;
        len[1] = 1; lbv[1] = 4; avail[1] = 1'b1;
        repeat (20) tick();
        chk("nofree_starts", 64'(start_cnt[1] - s0), 0);
        chk("nofree_grant", 64'(o_grant), 2);
        bfree = 2'b11;
        tick();
        chk("free_grant", 64'(o_grant), 1);
        chk("free_start_early", 64'(o_rd_start), 0);
        tick();
        chk("free_start", 64'(o_rd_start), 64'(4'b0010));
        wait_evt(d0, e0, "free_wait");
        chk("free_done_buf", 64'(done_q[d0].b), 0);
        chk("free_done_bytes", 64'(done_q[d0].by), 4);

        // Reset in the middle of a 4-word packet from engine 2 on buffer 1.
        d0 = done_q.size(); e0 = err_cnt; w0 = wr_q.size();
        len[2] = 4; lbv[2] = 7; avail[2] = 1'b1;
        i = 0;
        while (wr_q.size() < w0 + 2 && i < 100) begin
            tick();
            i++;
        end
        chk("rstmid_pre_buf", 64'(wr_q[w0].b), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_ram_write", 64'(o_ram_write), 0);
        chk("rstmid_ram_addr", 64'(o_ram_addr), 0);
        chk("rstmid_ram_buf", 64'(o_ram_buffer), 0);
        chk("rstmid_wdata", o_ram_wdata, 0);
        chk("rstmid_grant", 64'(o_grant), 0);
        chk("rstmid_pkt_words", 64'(o_packet_words), 0);
        chk("rstmid_pkt_bytes", 64'(o_packet_bytes), 0);
        repeat (6) tick();
        rst = 1'b0;
        tick();
        chk("rstmid_nwr", 64'(wr_q.size() - w0), 2);
        chk("rstmid_no_done", 64'(done_q.size() - d0), 0);
        chk("rstmid_no_err", 64'(err_cnt - e0), 0);
        g0 = grant_q.size();
        len[0] = 1; lbv[0] = 2; avail[0] = 1'b1; avail[2] = 1'b1;
        wait_grant(g0, "rstmid_regrant");
        chk("rstmid_regrant_eng", 64'(grant_q[g0]), 0);
        avail[2] = 1'b0;
        wait_evt(d0, e0, "rstmid_wait");
        chk("rstmid_done_buf", 64'(done_q[d0].b), 0);
        chk("rstmid_done_bytes", 64'(done_q[d0].by), 2);

        // Engine 1 never sends after rd_start: timeout abort, then rr moves on.
        d0 = done_q.size(); e0 = err_cnt; g0 = grant_q.size();
        silent[1] = 1'b1; avail[1] = 1'b1;
        wait_grant(g0, "tmo_grant_wait");
        sc = start_cyc;
        chk("tmo_grant", 64'(grant_q[g0]), 1);
        i = 0;
        while (err_cnt == e0 && i < 100) begin
            tick();
            i++;
        end
        chk("tmo_err", 64'(err_cnt - e0), 1);
        chk("tmo_latency", 64'(err_cyc - sc), 11);
        chk("tmo_no_done", 64'(done_q.size() - d0), 0);
        silent[1] = 1'b0; empty[1] = 1'b1;
        g0 = grant_q.size(); e0 = err_cnt;
        len[2] = 1; lbv[2] = 6; avail[1] = 1'b1; avail[2] = 1'b1;
        wait_grant(g0, "tmo_next_wait");
        chk("tmo_next_grant", 64'(grant_q[g0]), 2);
        avail[1] = 1'b0;
        wait_evt(d0, e0, "tmo_next_done");
        chk("tmo_next_buf", 64'(done_q[d0].b), 1);
        chk("tmo_next_bytes", 64'(done_q[d0].by), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
